// File: rtl/axilite_master_arb.sv
// Round-robin arbiter that shares one axilite master backend (start/done handshake)
// among NUM_REQ single-beat requesters, with an optional per-transaction timeout.
module axilite_master_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   bk_wstart,
  output logic [31:0]            bk_waddr,
  output logic [31:0]            bk_wdata,
  output logic [3:0]             bk_wstrb,
  input  logic                   bk_wdone,
  output logic                   bk_rstart,
  output logic [31:0]            bk_raddr,
  input  logic [31:0]            bk_rdata,
  input  logic                   bk_rdone
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, gnt_q, gnt_idx;
  logic            gnt_found, we_q, sel_we;
  logic [31:0]     addr_q, wdata_q, sel_addr, sel_wdata;
  logic [3:0]      wstrb_q, sel_wstrb;
  logic [CW-1:0]   cnt_q;
  logic            done_hit, timeout_hit;

  // Search starts just after the last granted requester, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    int cand;
    // NOTE: every variable gets a default before the loop; a path that skips an
    // assignment in always_comb would otherwise infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(cand);
        sel_we    = req_we[cand];
        sel_addr  = req_addr[cand*32 +: 32];
        sel_wdata = req_wdata[cand*32 +: 32];
        sel_wstrb = req_wstrb[cand*4 +: 4];
      end
    end
  end

  // A done of the other transfer type never completes the transaction.
  assign done_hit    = we_q ? bk_wdone : bk_rdone;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  // Grant is combinational; masked during reset so every output reads 0.
  assign req_ready = (state_q == IDLE && gnt_found && !axi_areset)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bk_waddr  = (busy &&  we_q) ? addr_q  : '0;
  assign bk_wdata  = (busy &&  we_q) ? wdata_q : '0;
  assign bk_wstrb  = (busy &&  we_q) ? wstrb_q : '0;
  assign bk_raddr  = (busy && !we_q) ? addr_q  : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      rr_ptr    <= PW'(NUM_REQ - 1);
      gnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      bk_wstart <= 1'b0;
      bk_rstart <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bk_wstart <= 1'b0;
      bk_rstart <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state_q)
        IDLE: if (gnt_found) begin
          gnt_q     <= gnt_idx;
          we_q      <= sel_we;
          addr_q    <= sel_addr;
          wdata_q   <= sel_wdata;
          wstrb_q   <= sel_wstrb;
          bk_wstart <= sel_we;
          bk_rstart <= !sel_we;
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (done_hit) begin
            rsp_valid <= NUM_REQ'(1) << gnt_q;
            rsp_rdata <= we_q ? 32'h0 : bk_rdata;
          end else if (timeout_hit) begin
            rsp_valid <= NUM_REQ'(1) << gnt_q;
            rsp_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    rr_ptr <= gnt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_master_arb.sv
// Scoreboard bench for axilite_master_arb: random requesters and backend responder,
// with a round-robin reference model predicting grants, starts and responses.
module tb_axilite_master_arb;

  localparam int N   = 4;
  localparam int TMO = 8;

  localparam int M_RAND   = 0;
  localparam int M_NORM   = 1;
  localparam int M_SPUR   = 2;
  localparam int M_TMO    = 3;
  localparam int M_SILENT = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          g;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic             axi_aclk = 1'b0;
  logic             axi_areset;
  logic [N-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [N*32-1:0]  req_addr, req_wdata;
  logic [N*4-1:0]   req_wstrb;
  logic [31:0]      rsp_rdata, bk_waddr, bk_wdata, bk_raddr, bk_rdata;
  logic             rsp_err, busy, bk_wstart, bk_rstart, bk_wdone, bk_rdone;
  logic [3:0]       bk_wstrb;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  req_t stim_q[N][$];
  exp_t exp_q[$];
  int   grant_log[$];

  // Reference model state
  int          last_g = N - 1;
  logic        m_busy = 1'b0;
  int          cur_g  = 0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;

  int resp_mode = M_NORM;
  int fix_delay = -1;

  axilite_master_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .bk_wstart (bk_wstart),
    .bk_waddr  (bk_waddr),
    .bk_wdata  (bk_wdata),
    .bk_wstrb  (bk_wstrb),
    .bk_wdone  (bk_wdone),
    .bk_rstart (bk_rstart),
    .bk_raddr  (bk_raddr),
    .bk_rdata  (bk_rdata),
    .bk_rdone  (bk_rdone)
  );

  always #5 axi_aclk = ~axi_aclk;
  always @(posedge axi_aclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int i, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.wstrb = s;
    stim_q[i].push_back(r);
  endtask

  function automatic bit all_idle();
    bit q_empty;
    q_empty = 1'b1;
    for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) q_empty = 1'b0;
    return q_empty && (req_valid == '0) && !m_busy && (exp_q.size() == 0);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      @(negedge axi_aclk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_grants(input int cnt, input int budget);
    int n;
    n = 0;
    while (n < budget && grant_log.size() < cnt) begin
      @(negedge axi_aclk);
      n++;
    end
    check("grant_seen", grant_log.size(), cnt);
  endtask

  // Requester agent: presents queued requests, holds valid until the accept pulse.
  initial begin : driver
    logic [N-1:0] acc;
    req_t r;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    forever begin
      @(negedge axi_aclk);
      acc = req_ready;
      @(posedge axi_aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && stim_q[i].size() > 0) begin
          r = stim_q[i].pop_front();
          req_we[i]              = r.we;
          req_addr[i*32 +: 32]   = r.addr;
          req_wdata[i*32 +: 32]  = r.wdata;
          req_wstrb[i*4 +: 4]    = r.wstrb;
          req_valid[i]           = 1'b1;
        end
      end
    end
  end

  // Backend responder: on each start decides the done timing and records the
  // response the requester should see.
  initial begin : responder
    logic        is_w;
    int          s, d, m;
    logic [31:0] rd;
    exp_t        e;
    bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;
    forever begin
      @(negedge axi_aclk);
      if (!axi_areset && (bk_wstart || bk_rstart)) begin
        is_w = bk_wstart;
        s    = cyc;
        m    = resp_mode;
        if (m == M_RAND) m = ($urandom_range(0, 3) == 0) ? M_SPUR : M_NORM;
        d    = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
        rd   = (cur_addr == 32'h3000_0004) ? 32'hDEAD_BEEF : $urandom;
        e.g  = cur_g;
        if (m == M_NORM || m == M_SPUR) begin
          if (m == M_SPUR && d == 0) d = 1;
          e.rdata = is_w ? 32'h0 : rd;
          e.err   = 1'b0;
          e.cyc   = s + 2 + d;
          exp_q.push_back(e);
          for (int k = 0; k <= d; k++) begin
            @(posedge axi_aclk);
            #1;
            bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;
            if (k == d) begin
              if (is_w) bk_wdone = 1'b1;
              else begin bk_rdone = 1'b1; bk_rdata = rd; end
            end else if (m == M_SPUR && k == 0) begin
              if (is_w) begin bk_rdone = 1'b1; bk_rdata = $urandom; end
              else bk_wdone = 1'b1;
            end
          end
          @(posedge axi_aclk);
          #1;
          bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;
          if (m == M_SPUR) begin
            @(posedge axi_aclk);
            #1;
            bk_wdone = 1'b1;
            @(posedge axi_aclk);
            #1;
            bk_wdone = 1'b0;
          end
        end else if (m == M_TMO) begin
          e.rdata = 32'h0;
          e.err   = 1'b1;
          e.cyc   = s + 1 + TMO;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: reference model of arbitration plus scoreboard pop on every response.
  always @(negedge axi_aclk) begin : monitor
    int           eg;
    logic [N-1:0] exp_ready;
    exp_t         e;
    if (axi_areset) begin
      m_busy = 1'b0;
      last_g = N - 1;
    end else begin
      eg = -1;
      for (int k = 1; k <= N; k++)
        if (eg < 0 && req_valid[(last_g + k) % N]) eg = (last_g + k) % N;
      exp_ready = (!m_busy && eg >= 0) ? N'(1 << eg) : '0;
      check("busy", busy, m_busy);
      if (exp_ready != '0 || req_ready != '0) check("req_ready", req_ready, exp_ready);
      if (exp_ready != '0) begin
        cur_g     = eg;
        cur_we    = req_we[eg];
        cur_addr  = req_addr[eg*32 +: 32];
        cur_wdata = req_wdata[eg*32 +: 32];
        cur_wstrb = req_wstrb[eg*4 +: 4];
        grant_log.push_back(eg);
        last_g    = eg;
        m_busy    = 1'b1;
      end else if (m_busy) begin
        check("bk_waddr", bk_waddr, cur_we ? cur_addr  : 32'h0);
        check("bk_wdata", bk_wdata, cur_we ? cur_wdata : 32'h0);
        check("bk_wstrb", bk_wstrb, cur_we ? cur_wstrb : 4'h0);
        check("bk_raddr", bk_raddr, cur_we ? 32'h0 : cur_addr);
      end
      if (bk_wstart || bk_rstart) begin
        check("bk_wstart", bk_wstart, cur_we);
        check("bk_rstart", bk_rstart, !cur_we);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", rsp_valid, 32'(1) << e.g);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err",   rsp_err,   e.err);
          check("rsp_cycle", cyc,       e.cyc);
        end
        m_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    int exp1[5];
    int exp2[3];
    int exp3[2];
    exp1 = '{0, 1, 2, 3, 0};
    exp2 = '{2, 3, 1};
    exp3 = '{0, 2};

    // Directed write/read and round-robin from reset: all four valid while in reset.
    axi_areset = 1'b1;
    resp_mode  = M_NORM;
    fix_delay  = 2;
    push_req(0, 1'b0, 32'h3000_0004, 32'h0, 4'h0);
    push_req(1, 1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF);
    push_req(2, 1'b1, 32'h3000_0020, 32'h1111_2222, 4'h3);
    push_req(3, 1'b0, 32'h3000_0030, 32'h0, 4'h0);
    push_req(0, 1'b1, 32'h3000_0040, 32'h5555_AAAA, 4'hC);
    repeat (4) @(posedge axi_aclk);
    #1;
    check("rst_req_ready", req_ready, 32'h0);
    check("rst_rsp_valid", rsp_valid, 32'h0);
    check("rst_busy",      busy,      32'h0);
    check("rst_bk_start",  {bk_wstart, bk_rstart}, 32'h0);
    check("rst_bk_waddr",  bk_waddr,  32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    axi_areset = 1'b0;
    drain(400);
    check("rr_len", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp1[i]);

    // Requesters 1 and 3 appear only after the grant to 2.
    grant_log.delete();
    fix_delay = -1;
    push_req(2, 1'b0, 32'h3000_0100, 32'h0, 4'h0);
    wait_grants(1, 50);
    push_req(1, 1'b1, 32'h3000_0104, 32'hCAFE_0001, 4'hF);
    push_req(3, 1'b1, 32'h3000_0108, 32'hCAFE_0003, 4'h1);
    drain(400);
    check("rr2_len", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) check("rr2_order", grant_log[i], exp2[i]);

    // Random traffic, mixing clean and spurious-done transactions.
    resp_mode = M_RAND;
    for (int n = 0; n < 40; n++) begin
      push_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 6)) @(posedge axi_aclk);
    end
    drain(3000);

    // Timeout, then a normal transaction afterwards.
    resp_mode = M_TMO;
    push_req(2, 1'b0, 32'h3000_0200, 32'h0, 4'h0);
    drain(200);
    resp_mode = M_NORM;
    push_req(3, 1'b1, 32'h3000_0204, 32'h7777_8888, 4'hF);
    drain(200);

    // Mismatched done in WAIT and a write done in IDLE.
    resp_mode = M_SPUR;
    fix_delay = 2;
    push_req(1, 1'b1, 32'h3000_0300, 32'h1234_5678, 4'hF);
    drain(200);
    repeat (4) @(posedge axi_aclk);

    // Reset while the transaction sits in WAIT.
    resp_mode = M_SILENT;
    fix_delay = -1;
    grant_log.delete();
    push_req(2, 1'b1, 32'h3000_0400, 32'hFFFF_0000, 4'hF);
    wait_grants(1, 50);
    repeat (3) @(posedge axi_aclk);
    #1;
    check("pre_rst_busy", busy, 32'h1);
    axi_areset = 1'b1;
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;
    check("mid_rst_busy",      busy,      32'h0);
    check("mid_rst_rsp_valid", rsp_valid, 32'h0);
    check("mid_rst_bk_waddr",  bk_waddr,  32'h0);
    check("mid_rst_bk_wdata",  bk_wdata,  32'h0);
    check("mid_rst_req_ready", req_ready, 32'h0);
    repeat (15) @(posedge axi_aclk);
    resp_mode = M_NORM;
    grant_log.delete();
    push_req(2, 1'b0, 32'h3000_0500, 32'h0, 4'h0);
    push_req(0, 1'b0, 32'h3000_0504, 32'h0, 4'h0);
    drain(200);
    check("post_rst_len", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++) check("post_rst_order", grant_log[i], exp3[i]);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axilite_master_arb.md
Name: axilite_master_arb

Overview:
- Round-robin arbiter and sequencer that shares one axilite master backend port (bk_* start/done interface) among NUM_REQ requesters.
- Each requester presents a single-beat read or write. The block grants one requester, issues exactly one bk_wstart or bk_rstart pulse, and waits for the matching done.
- It then returns a one-cycle response to the granted requester.
- Sits between fsic control sources (mailbox, config engine, host bridge) and the axilite master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 255, cycles waited in WAIT before an error response; 0 disables the timeout.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  synchronous reset, active high.
- req_valid  in  NUM_REQ  request pending, one bit per requester; held until req_ready.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*32  address, requester i at [32i+31:32i].
- req_wdata  in  NUM_REQ*32  write data.
- req_wstrb  in  NUM_REQ*4  write strobes.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  32  read data; valid with rsp_valid.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- bk_wstart  out  1  write start pulse.
- bk_waddr  out  32  write address.
- bk_wdata  out  32  write data.
- bk_wstrb  out  4  write strobes.
- bk_wdone  in  1  write done pulse.
- bk_rstart  out  1  read start pulse.
- bk_raddr  out  32  read address.
- bk_rdata  in  32  read data; valid with bk_rdone.
- bk_rdone  in  1  read done pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1; counter 0.
- Reset mid-transaction abandons the transaction with no response.
- Reset takes priority over all other events.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i] set, searching from rr_ptr+1 upward with wrap mod NUM_REQ.
  - Grant is combinational. req_ready[g] = 1 in that same cycle.
  - On that edge, latch g, we, addr, wdata and wstrb; go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE (one cycle):
  - Registered bk_wstart = we or bk_rstart = !we, exactly one pulse.
  - bk_waddr/bk_wdata/bk_wstrb or bk_raddr driven from the latched values, held stable from ISSUE through RESP.
  - The unused channel's data is driven to 0.
  - Go to WAIT; clear the counter.
- WAIT:
  - Write waits for bk_wdone; read waits for bk_rdone.
  - Done of the other type is ignored.
  - On the matching done: capture rdata = bk_rdata for reads, 0 for writes; err = 0; go to RESP.
  - Otherwise the counter increments.
  - With TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1 with no done: rdata = 0, err = 1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP (one cycle):
  - rsp_valid[g] = 1; rsp_rdata and rsp_err registered and valid this cycle only. Both return to 0 afterwards.
  - rr_ptr <= g; go to IDLE.
- Minimum latency: accept at cycle T, start at T+1, done earliest at T+2, rsp_valid at T+3. A new accept is possible at T+4.
- Done pulses arriving outside WAIT are ignored.
- Fairness: every continuously valid requester is granted within NUM_REQ transactions.
- Limitation: TIMEOUT_CYC must exceed the worst-case master latency. A done that arrives after a timeout is indistinguishable from the next transaction's done.

Test Plan:
- Single write, requester 1: addr 0x3000_0010, data 0xA5A5_1234, strb 0xF; bk_wdone 3 cycles after bk_wstart.
  - Expect req_ready[1] at T, one bk_wstart at T+1 with those values, rsp_valid[1] one cycle after wdone, rsp_err = 0, rsp_rdata = 0.
- Single read, requester 0: addr 0x3000_0004; bk_rdone with bk_rdata = 0xDEAD_BEEF.
  - Expect one bk_rstart, bk_wstart never asserted, rsp_valid[0] with rsp_rdata = 0xDEAD_BEEF.
- Round-robin: all 4 requesters held valid from reset.
  - Expect grant order 0, 1, 2, 3, 0. With requesters 1 and 3 only valid after a grant to 2, expect 3 then 1.
- Timeout: TIMEOUT_CYC = 8, done never asserted.
  - Expect rsp_valid 9 cycles after the start pulse (8 WAIT cycles plus RESP) with rsp_err = 1, rsp_rdata = 0; the next request proceeds normally.
- Spurious and mismatched dones:
  - bk_rdone pulsed during a write WAIT, and bk_wdone pulsed in IDLE.
  - Expect both ignored; the write completes only on bk_wdone.
- Reset in WAIT:
  - Assert axi_areset one cycle.
  - Expect all outputs 0, busy = 0, no rsp_valid; the next request is granted starting from requester 0.
